// File: rtl/apb_master_ctrl_if.sv
// Bundle of the command port, response port and APB3 bus around apb_master_ctrl.
// The master modport is the bridge's view; slave is the view of whatever surrounds it.
interface apb_master_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// Single-outstanding command-to-APB3 bridge with PREADY timeout.
// Every output is a register; the comb process computes next values for all of them.
module apb_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_ctrl_if.master    bus,
    output logic [1:0]           o_dbg_state
);
    // Handshakes: a beat transfers on the posedge where valid && ready are both 1;
    // the sender holds its payload stable while valid is high and ready is low.

    localparam int WCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] CNT_MAX = '1;
    localparam logic [WCW-1:0] TO_VAL  = WCW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                r_state, w_state_d;
    logic [WCW-1:0]        r_wait_cnt, w_wait_cnt_d, w_cnt_inc;
    logic                  r_cmd_ready, w_cmd_ready_d;
    logic                  r_rsp_valid, w_rsp_valid_d;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_d;
    logic                  r_rsp_err, w_rsp_err_d;
    logic                  r_rsp_timeout, w_rsp_timeout_d;
    logic                  r_psel, w_psel_d;
    logic                  r_penable, w_penable_d;
    logic                  r_pwrite, w_pwrite_d;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_d;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_d;

    assign w_cnt_inc = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + WCW'(1);

    always_comb begin
        w_state_d       = r_state;
        w_wait_cnt_d    = r_wait_cnt;
        w_cmd_ready_d   = r_cmd_ready;
        w_rsp_valid_d   = r_rsp_valid;
        w_rsp_rdata_d   = r_rsp_rdata;
        w_rsp_err_d     = r_rsp_err;
        w_rsp_timeout_d = r_rsp_timeout;
        w_psel_d        = r_psel;
        w_penable_d     = r_penable;
        w_pwrite_d      = r_pwrite;
        w_paddr_d       = r_paddr;
        w_pwdata_d      = r_pwdata;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_pwrite_d    = bus.cmd_write;
                    w_paddr_d     = bus.cmd_addr;
                    w_pwdata_d    = bus.cmd_wdata;
                    w_psel_d      = 1'b1;
                    w_cmd_ready_d = 1'b0;
                    w_wait_cnt_d  = '0;
                    w_state_d     = SETUP;
                end
            end
            SETUP: begin
                w_penable_d = 1'b1;
                w_state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_rsp_rdata_d   = r_pwrite ? '0 : bus.PRDATA;
                    w_rsp_err_d     = bus.PSLVERR;
                    w_rsp_timeout_d = 1'b0;
                    w_psel_d        = 1'b0;
                    w_penable_d     = 1'b0;
                    w_rsp_valid_d   = 1'b1;
                    w_state_d       = RESP;
                end else begin
                    w_wait_cnt_d = w_cnt_inc;
                    // Abort on the edge that completes the last permitted wait cycle.
                    if (TIMEOUT_CYCLES != 0 && w_cnt_inc == TO_VAL) begin
                        w_rsp_rdata_d   = '0;
                        w_rsp_err_d     = 1'b1;
                        w_rsp_timeout_d = 1'b1;
                        w_psel_d        = 1'b0;
                        w_penable_d     = 1'b0;
                        w_rsp_valid_d   = 1'b1;
                        w_state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    w_cmd_ready_d = 1'b1;
                    w_state_d     = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wait_cnt    <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
        end else begin
            r_wait_cnt    <= w_wait_cnt_d;
            r_cmd_ready   <= w_cmd_ready_d;
            r_rsp_valid   <= w_rsp_valid_d;
            r_rsp_rdata   <= w_rsp_rdata_d;
            r_rsp_err     <= w_rsp_err_d;
            r_rsp_timeout <= w_rsp_timeout_d;
            r_psel        <= w_psel_d;
            r_penable     <= w_penable_d;
            r_pwrite      <= w_pwrite_d;
            r_paddr       <= w_paddr_d;
            r_pwdata      <= w_pwdata_d;
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl (TIMEOUT_CYCLES=4) against a small APB memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_apb_master_ctrl;
    logic       PCLK;
    logic       PRESET;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    logic [31:0] mem [16];

    apb_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave memory: word-indexed, combinational read, write on completed ACCESS.
    assign bus.PRDATA = mem[bus.PADDR[5:2]];
    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
            mem[bus.PADDR[5:2]] <= bus.PWDATA;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        step(); step();

        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_state", dbg_state, 0);
        PRESET = 1'b0;

        // Zero-wait write
        send_cmd(1'b1, 32'h04, 32'hDEAD_BEEF);
        bus.PREADY    = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        chk("wr_t1_psel", bus.PSEL, 1);
        chk("wr_t1_penable", bus.PENABLE, 0);
        chk("wr_t1_cmd_ready", bus.cmd_ready, 0);
        chk("wr_t1_paddr", bus.PADDR, 32'h04);
        chk("wr_t1_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        chk("wr_t1_pwrite", bus.PWRITE, 1);
        step();
        chk("wr_t2_psel", bus.PSEL, 1);
        chk("wr_t2_penable", bus.PENABLE, 1);
        chk("wr_t2_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        chk("wr_t2_state", dbg_state, 2);
        step();
        chk("wr_t3_rsp_valid", bus.rsp_valid, 1);
        chk("wr_t3_rsp_err", bus.rsp_err, 0);
        chk("wr_t3_rsp_rdata", bus.rsp_rdata, 0);
        chk("wr_t3_psel", bus.PSEL, 0);
        step();
        chk("wr_t4_cmd_ready", bus.cmd_ready, 1);
        chk("wr_t4_rsp_valid", bus.rsp_valid, 0);
        chk("wr_t4_paddr_kept", bus.PADDR, 32'h04);

        // Read-back
        send_cmd(1'b0, 32'h04, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        chk("rd_t1_psel", bus.PSEL, 1);
        chk("rd_t1_pwrite", bus.PWRITE, 0);
        step();
        chk("rd_t2_penable", bus.PENABLE, 1);
        step();
        chk("rd_t3_rsp_valid", bus.rsp_valid, 1);
        chk("rd_t3_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_t3_rsp_err", bus.rsp_err, 0);
        step();

        // Three wait states, then PREADY
        bus.PREADY = 1'b0;
        send_cmd(1'b1, 32'h08, 32'h1234_5678);
        step();
        bus.cmd_valid = 1'b0;
        chk("ws_setup_penable", bus.PENABLE, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ws_acc%0d_penable", i), bus.PENABLE, 1);
            chk($sformatf("ws_acc%0d_paddr", i), bus.PADDR, 32'h08);
            chk($sformatf("ws_acc%0d_pwdata", i), bus.PWDATA, 32'h1234_5678);
            chk($sformatf("ws_acc%0d_rsp_valid", i), bus.rsp_valid, 0);
            if (i == 3) bus.PREADY = 1'b1;
        end
        step();
        chk("ws_rsp_valid", bus.rsp_valid, 1);
        chk("ws_penable_low", bus.PENABLE, 0);
        chk("ws_rsp_timeout", bus.rsp_timeout, 0);
        step();

        // Timeout: PREADY stuck low, read of a non-zero word
        bus.PREADY = 1'b0;
        send_cmd(1'b0, 32'h04, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("to_acc%0d_psel", i), bus.PSEL, 1);
            chk($sformatf("to_acc%0d_penable", i), bus.PENABLE, 1);
        end
        step();
        chk("to_psel", bus.PSEL, 0);
        chk("to_penable", bus.PENABLE, 0);
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_err", bus.rsp_err, 1);
        chk("to_rsp_timeout", bus.rsp_timeout, 1);
        chk("to_rsp_rdata", bus.rsp_rdata, 0);
        step();

        // Slave error with response backpressure; a stray command must be ignored
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b1;
        send_cmd(1'b0, 32'h04, 32'h0);
        step();
        send_cmd(1'b1, 32'h20, 32'hAAAA_5555);
        step();
        step();
        bus.PSLVERR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rsp_valid", i), bus.rsp_valid, 1);
            chk($sformatf("bp%0d_rsp_err", i), bus.rsp_err, 1);
            chk($sformatf("bp%0d_cmd_ready", i), bus.cmd_ready, 0);
            chk($sformatf("bp%0d_psel", i), bus.PSEL, 0);
            chk($sformatf("bp%0d_rdata", i), bus.rsp_rdata, 32'hDEAD_BEEF);
            if (i < 4) step();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_done_rsp_valid", bus.rsp_valid, 0);
        chk("bp_done_cmd_ready", bus.cmd_ready, 1);
        chk("bp_done_paddr", bus.PADDR, 32'h04);

        // Reset during ACCESS
        bus.PREADY = 1'b0;
        send_cmd(1'b1, 32'h0C, 32'h0BAD_F00D);
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("rm_in_access", bus.PENABLE, 1);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        chk("rm_psel", bus.PSEL, 0);
        chk("rm_penable", bus.PENABLE, 0);
        chk("rm_cmd_ready", bus.cmd_ready, 1);
        chk("rm_paddr", bus.PADDR, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rm%0d_rsp_valid", i), bus.rsp_valid, 0);
            chk($sformatf("rm%0d_state", i), dbg_state, 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
